// File: rtl/hit_scorer_pkg.sv
// Shared definitions for the whack-a-mole game-logic slice: hole count,
// FSM state codes, default game length and the judging outcome type.
package hit_scorer_pkg;

  // Number of mole holes / lights on the board.
  localparam int NUM_LIGHTS = 9;

  // Game FSM state codes; code 3 is unused and recovers to IDLE.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Flicks per game unless the instantiation overrides it.
  localparam logic [5:0] DEFAULT_NUM_FLICKS = 6'd30;

  // Outcome of judging one cycle of play.
  typedef enum logic [1:0] {
    JUDGE_NONE = 2'd0,
    JUDGE_HIT  = 2'd1,
    JUDGE_MISS = 2'd2
  } judge_e;

endpackage

// File: rtl/hit_scorer_btn_sync.sv
// Per-bit two-flop synchroniser followed by a rising-edge detector.
// A pin that rises before edge k produces a one-cycle press after edge k+1.
module hit_scorer_btn_sync #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] pin_i,
  output logic [W-1:0] press_o
);

  logic [W-1:0] sync1_q;
  logic [W-1:0] sync2_q;
  logic [W-1:0] prev_q;

  // Metastability filter plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign press_o = sync2_q & ~prev_q;

endmodule

// File: rtl/hit_scorer.sv
// Game-logic stage behind the LED flicker controller: conditions the mole
// and start buttons, judges each press against the lit hole, keeps saturating
// hit/miss scores and gates the flicker controller via game_active.
module hit_scorer
  import hit_scorer_pkg::*;
#(
  parameter logic [5:0] NUM_FLICKS = DEFAULT_NUM_FLICKS,
  parameter int         SCORE_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_btn,
  input  logic [NUM_LIGHTS-1:0] buttons,
  input  logic [NUM_LIGHTS-1:0] lights,
  input  logic [5:0]            light_counter,
  output logic                  game_active,
  output logic [SCORE_W-1:0]    score,
  output logic [SCORE_W-1:0]    misses,
  output logic                  hit_pulse,
  output logic                  miss_pulse,
  output logic                  game_over
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic [NUM_LIGHTS:0]   press_all;
  logic [NUM_LIGHTS-1:0] press;
  logic                  start_press;

  logic [1:0]            state_q, state_d;
  logic [NUM_LIGHTS-1:0] lights_q;
  logic [NUM_LIGHTS-1:0] target_q, target_d;
  logic                  armed_q, armed_d;
  logic [SCORE_W-1:0]    score_q, score_d;
  logic [SCORE_W-1:0]    misses_q, misses_d;
  logic                  hit_q, hit_d;
  logic                  miss_q, miss_d;

  logic                  light_rise;
  logic                  light_drop;
  logic                  window_open;
  logic [NUM_LIGHTS-1:0] tgt;
  judge_e                judge;

  // Start button rides in the top bit so all ten inputs share one synchroniser.
  hit_scorer_btn_sync #(
    .W(NUM_LIGHTS + 1)
  ) u_btn_sync (
    .clk    (clk),
    .reset  (reset),
    .pin_i  ({start_btn, buttons}),
    .press_o(press_all)
  );

  assign press       = press_all[NUM_LIGHTS-1:0];
  assign start_press = press_all[NUM_LIGHTS];

  assign light_rise  = (lights_q == '0) && (lights != '0);
  assign light_drop  = (lights_q != '0) && (lights == '0);
  // A press in the light's first cycle is judged against the live lights.
  assign window_open = armed_q | light_rise;
  assign tgt         = armed_q ? target_q : lights;

  // Judge presses and timeouts; only meaningful while a game is running.
  always_comb begin
    judge = JUDGE_NONE;
    if (state_q == ST_PLAY) begin
      if (window_open && (press != '0)) begin
        judge = (press == tgt) ? JUDGE_HIT : JUDGE_MISS;
      end else if (light_drop && armed_q) begin
        judge = JUDGE_MISS;
      end
    end
  end

  // Next-state logic for the FSM, window tracking and score counters.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    armed_d  = armed_q;
    score_d  = score_q;
    misses_d = misses_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_press) begin
          state_d  = ST_PLAY;
          score_d  = '0;
          misses_d = '0;
          armed_d  = 1'b0;
        end
      end
      ST_PLAY: begin
        if (judge != JUDGE_NONE) begin
          // Any judgement, including a timeout, closes the window.
          armed_d = 1'b0;
        end else if (light_rise) begin
          armed_d  = 1'b1;
          target_d = lights;
        end
        if (judge == JUDGE_HIT) begin
          hit_d = 1'b1;
          if (score_q != SCORE_MAX) score_d = score_q + 1'b1;
        end else if (judge == JUDGE_MISS) begin
          miss_d = 1'b1;
          if (misses_q != SCORE_MAX) misses_d = misses_q + 1'b1;
        end
        // Wait for the last light to be judged before ending the game.
        if ((light_counter == NUM_FLICKS) && (lights == '0) && !armed_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; the async reset also clears scores mid-game.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      lights_q <= '0;
      target_q <= '0;
      armed_q  <= 1'b0;
      score_q  <= '0;
      misses_q <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lights_q <= lights;
      target_q <= target_d;
      armed_q  <= armed_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  assign game_active = (state_q == ST_PLAY);
  assign game_over   = (state_q == ST_DONE);
  assign score       = score_q;
  assign misses      = misses_q;
  assign hit_pulse   = hit_q;
  assign miss_pulse  = miss_q;

endmodule

// File: tb/tb_hit_scorer.sv
// Directed self-checking bench for hit_scorer. Inputs are driven and outputs
// sampled on the falling clock edge, away from the active rising edge.
module tb_hit_scorer;

  localparam logic [5:0] NF = 6'd30;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_btn = 1'b0;
  logic [8:0] buttons = '0;
  logic [8:0] lights = '0;
  logic [5:0] light_counter = '0;
  logic       game_active;
  logic [7:0] score;
  logic [7:0] misses;
  logic       hit_pulse;
  logic       miss_pulse;
  logic       game_over;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  hit_scorer #(
    .NUM_FLICKS(NF),
    .SCORE_W   (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_btn    (start_btn),
    .buttons      (buttons),
    .lights       (lights),
    .light_counter(light_counter),
    .game_active  (game_active),
    .score        (score),
    .misses       (misses),
    .hit_pulse    (hit_pulse),
    .miss_pulse   (miss_pulse),
    .game_over    (game_over)
  );

  // Advance n rising edges, landing on the following falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start_btn = 1'b0;
    buttons = '0;
    lights = '0;
    light_counter = '0;
    cyc(2);
    reset = 1'b1;
    cyc(1);
  endtask

  // One-cycle button pulse; returns the pulses seen once the press is judged.
  task automatic press(input logic [8:0] b, output logic h, output logic m);
    buttons = b;
    cyc(1);
    buttons = '0;
    cyc(2);
    h = hit_pulse;
    m = miss_pulse;
  endtask

  task automatic start_game();
    do_reset();
    start_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0;
    cyc(2);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc(2);
    tests_run++;
    if ({game_active, game_over, hit_pulse, miss_pulse, score, misses} !== 20'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got ga=%b go=%b hp=%b mp=%b sc=%0d mi=%0d required all 0",
               game_active, game_over, hit_pulse, miss_pulse, score, misses);
    end
    reset = 1'b1;
    cyc(3);
    tests_run++;
    if (game_active !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: game_active=%b required 0", game_active);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_start();
    do_reset();
    start_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0;
    cyc(1);
    tests_run++;
    if (game_active !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_early: game_active=%b required 0 two edges after pin", game_active);
    end
    cyc(1);
    tests_run++;
    if (game_active !== 1'b1 || score !== 8'd0 || misses !== 8'd0 || game_over !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_play: ga=%b sc=%0d mi=%0d go=%b required 1 0 0 0",
               game_active, score, misses, game_over);
    end
    $display("[TB] test_start done");
  endtask

  task automatic test_hit_window();
    logic h, m;
    start_game();
    lights = 9'h010;
    cyc(5);
    press(9'h010, h, m);
    tests_run++;
    if (h !== 1'b1 || m !== 1'b0 || score !== 8'd1) begin
      tests_failed++;
      $display("FAIL hit_first: hp=%b mp=%b sc=%0d required 1 0 1", h, m, score);
    end
    cyc(1);
    tests_run++;
    if (hit_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL hit_pulse_width: hp=%b required 0 one cycle later", hit_pulse);
    end
    press(9'h010, h, m);
    tests_run++;
    if (h !== 1'b0 || m !== 1'b0 || score !== 8'd1) begin
      tests_failed++;
      $display("FAIL hit_second_ignored: hp=%b mp=%b sc=%0d required 0 0 1", h, m, score);
    end
    cyc(8);
    lights = '0;
    cyc(2);
    tests_run++;
    if (misses !== 8'd0) begin
      tests_failed++;
      $display("FAIL hit_no_timeout: misses=%0d required 0", misses);
    end
    $display("[TB] test_hit_window done");
  endtask

  task automatic test_wrong_button();
    logic h, m;
    start_game();
    lights = 9'h010;
    cyc(2);
    press(9'h011, h, m);
    tests_run++;
    if (h !== 1'b0 || m !== 1'b1 || misses !== 8'd1 || score !== 8'd0) begin
      tests_failed++;
      $display("FAIL wrong_button: hp=%b mp=%b mi=%0d sc=%0d required 0 1 1 0", h, m, misses, score);
    end
    lights = '0;
    cyc(2);
    tests_run++;
    if (misses !== 8'd1) begin
      tests_failed++;
      $display("FAIL wrong_no_timeout: misses=%0d required 1", misses);
    end
    $display("[TB] test_wrong_button done");
  endtask

  task automatic test_timeout();
    start_game();
    lights = 9'h004;
    cyc(3);
    lights = '0;
    cyc(1);
    tests_run++;
    if (miss_pulse !== 1'b1 || hit_pulse !== 1'b0 || misses !== 8'd1) begin
      tests_failed++;
      $display("FAIL timeout_miss: mp=%b hp=%b mi=%0d required 1 0 1", miss_pulse, hit_pulse, misses);
    end
    cyc(1);
    tests_run++;
    if (miss_pulse !== 1'b0 || misses !== 8'd1) begin
      tests_failed++;
      $display("FAIL timeout_once: mp=%b mi=%0d required 0 1", miss_pulse, misses);
    end
    $display("[TB] test_timeout done");
  endtask

  task automatic test_press_on_drop();
    logic h, m;
    start_game();
    lights = 9'h100;
    cyc(2);
    buttons = 9'h100;
    cyc(1);
    buttons = '0;
    cyc(1);
    lights = '0;
    cyc(1);
    tests_run++;
    if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0 || score !== 8'd1) begin
      tests_failed++;
      $display("FAIL drop_hit: hp=%b mp=%b sc=%0d required 1 0 1", hit_pulse, miss_pulse, score);
    end
    cyc(1);
    tests_run++;
    if (miss_pulse !== 1'b0 || misses !== 8'd0) begin
      tests_failed++;
      $display("FAIL drop_no_timeout: mp=%b mi=%0d required 0 0", miss_pulse, misses);
    end
    press(9'h100, h, m);
    tests_run++;
    if (h !== 1'b0 || m !== 1'b0 || score !== 8'd1 || misses !== 8'd0) begin
      tests_failed++;
      $display("FAIL dark_press: hp=%b mp=%b sc=%0d mi=%0d required 0 0 1 0", h, m, score, misses);
    end
    $display("[TB] test_press_on_drop done");
  endtask

  task automatic test_game_over();
    logic h, m;
    start_game();
    light_counter = NF - 6'd1;
    cyc(2);
    tests_run++;
    if (game_active !== 1'b1 || game_over !== 1'b0) begin
      tests_failed++;
      $display("FAIL over_early: ga=%b go=%b required 1 0 at count NF-1", game_active, game_over);
    end
    light_counter = NF;
    lights = 9'h001;
    cyc(2);
    lights = '0;
    cyc(1);
    tests_run++;
    if (miss_pulse !== 1'b1 || game_active !== 1'b1) begin
      tests_failed++;
      $display("FAIL over_last_timeout: mp=%b ga=%b required 1 1", miss_pulse, game_active);
    end
    cyc(1);
    tests_run++;
    if (game_over !== 1'b1 || game_active !== 1'b0 || misses !== 8'd1) begin
      tests_failed++;
      $display("FAIL over_enter: go=%b ga=%b mi=%0d required 1 0 1", game_over, game_active, misses);
    end
    start_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0;
    cyc(3);
    tests_run++;
    if (game_over !== 1'b1 || game_active !== 1'b0) begin
      tests_failed++;
      $display("FAIL over_start_ignored: go=%b ga=%b required 1 0", game_over, game_active);
    end
    lights = 9'h002;
    cyc(1);
    press(9'h002, h, m);
    tests_run++;
    if (h !== 1'b0 || m !== 1'b0 || score !== 8'd0 || misses !== 8'd1) begin
      tests_failed++;
      $display("FAIL over_press_ignored: hp=%b mp=%b sc=%0d mi=%0d required 0 0 0 1", h, m, score, misses);
    end
    lights = '0;
    $display("[TB] test_game_over done");
  endtask

  task automatic test_saturation();
    logic h, m;
    logic [8:0] one;
    int hits;
    one = 9'h001;
    hits = 0;
    start_game();
    for (int i = 0; i < 300; i++) begin
      lights = one << (i % 9);
      cyc(1);
      press(lights, h, m);
      if (h === 1'b1) hits++;
      lights = '0;
      cyc(1);
      if (i == 254) begin
        tests_run++;
        if (score !== 8'd255) begin
          tests_failed++;
          $display("FAIL sat_reach: score=%0d required 255 after 255 hits", score);
        end
      end
    end
    tests_run++;
    if (score !== 8'd255 || misses !== 8'd0 || hits != 300) begin
      tests_failed++;
      $display("FAIL sat_hold: score=%0d mi=%0d pulses=%0d required 255 0 300", score, misses, hits);
    end
    $display("[TB] test_saturation done");
  endtask

  task automatic test_async_reset();
    logic h, m;
    start_game();
    lights = 9'h010;
    cyc(1);
    press(9'h010, h, m);
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (score !== 8'd0 || game_active !== 1'b0 || hit_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: sc=%0d ga=%b hp=%b required 0 0 0 before next edge",
               score, game_active, hit_pulse);
    end
    @(negedge clk);
    reset = 1'b1;
    lights = '0;
    cyc(2);
    tests_run++;
    if (game_active !== 1'b0 || score !== 8'd0) begin
      tests_failed++;
      $display("FAIL async_reset_idle: ga=%b sc=%0d required 0 0", game_active, score);
    end
    $display("[TB] test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_start();
    test_hit_window();
    test_wrong_button();
    test_timeout();
    test_press_on_drop();
    test_game_over();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
